// File: rtl/alu_pipe.sv
// Handshaked RV32I-style ALU / branch comparator with an iterative shifter.
// Results and flags are registered and held until the consumer takes them.
module alu_pipe #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic            soc_clk,
  input  logic            reset_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_dat1,
  input  logic [XLEN-1:0] in_dat2,
  input  logic [2:0]      in_funct3,
  input  logic            in_diff,
  input  logic            in_branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_branch,
  output logic            out_zero,
  output logic            out_negative,
  output logic            out_overflow,
  output logic            out_carry,
  output logic            out_illegal
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shkind_t;

  state_t          state_r, state_nx;
  shkind_t         kind_r, kind_s;
  logic [SHW-1:0]  remaining_r, step_s, shamt_s;
  logic [XLEN-1:0] shift_val_r, shifted_s;
  logic [XLEN-1:0] result_r, res_s;
  logic [XLEN:0]   sum_s, sub_s;
  logic            branch_r, zero_r, negative_r, overflow_r, carry_r, illegal_r;
  logic            br_s, zero_s, ovf_s, cy_s, illegal_s, is_shift_s;
  logic            accept_s, shift_now_s, shift_last_s;

  // Decode and single-cycle execute straight from the offered operands
  always_comb begin
    sum_s      = {1'b0, in_dat1} + {1'b0, in_dat2};
    sub_s      = {1'b0, in_dat1} - {1'b0, in_dat2};
    shamt_s    = in_dat2[SHW-1:0];
    res_s      = '0;
    br_s       = 1'b0;
    ovf_s      = 1'b0;
    cy_s       = 1'b0;
    illegal_s  = 1'b0;
    is_shift_s = 1'b0;
    kind_s     = SH_LL;
    if (in_branch) begin
      if (in_diff) begin
        illegal_s = 1'b1;
      end else begin
        case (in_funct3)
          3'b000:  br_s = (in_dat1 == in_dat2);
          3'b001:  br_s = (in_dat1 != in_dat2);
          3'b100:  br_s = ($signed(in_dat1) < $signed(in_dat2));
          3'b101:  br_s = !($signed(in_dat1) < $signed(in_dat2));
          3'b110:  br_s = (in_dat1 < in_dat2);
          3'b111:  br_s = !(in_dat1 < in_dat2);
          default: illegal_s = 1'b1;
        endcase
      end
    end else if (in_diff) begin
      case (in_funct3)
        3'b000: begin
          res_s = sub_s[XLEN-1:0];
          cy_s  = sub_s[XLEN];
          ovf_s = (in_dat1[XLEN-1] != in_dat2[XLEN-1]) && (sub_s[XLEN-1] != in_dat1[XLEN-1]);
        end
        3'b101: begin
          res_s      = in_dat1;
          is_shift_s = 1'b1;
          kind_s     = SH_RA;
        end
        default: illegal_s = 1'b1;
      endcase
    end else begin
      case (in_funct3)
        3'b000: begin
          res_s = sum_s[XLEN-1:0];
          cy_s  = sum_s[XLEN];
          ovf_s = (in_dat1[XLEN-1] == in_dat2[XLEN-1]) && (sum_s[XLEN-1] != in_dat1[XLEN-1]);
        end
        3'b001: begin
          res_s      = in_dat1;
          is_shift_s = 1'b1;
          kind_s     = SH_LL;
        end
        3'b010:  res_s = {{(XLEN-1){1'b0}}, ($signed(in_dat1) < $signed(in_dat2))};
        3'b011:  res_s = {{(XLEN-1){1'b0}}, (in_dat1 < in_dat2)};
        3'b100:  res_s = in_dat1 ^ in_dat2;
        3'b101: begin
          res_s      = in_dat1;
          is_shift_s = 1'b1;
          kind_s     = SH_RL;
        end
        3'b110:  res_s = in_dat1 | in_dat2;
        3'b111:  res_s = in_dat1 & in_dat2;
        default: illegal_s = 1'b1;
      endcase
    end
    if (in_branch) begin
      zero_s = (in_dat1 == in_dat2);
    end else begin
      zero_s = (res_s == '0);
    end
  end

  // One iteration of the shifter; the arithmetic shift keeps refilling with the original sign
  always_comb begin
    if ({1'b0, remaining_r} > STEP) begin
      step_s = STEP[SHW-1:0];
    end else begin
      step_s = remaining_r;
    end
    case (kind_r)
      SH_LL:   shifted_s = shift_val_r << step_s;
      SH_RL:   shifted_s = shift_val_r >> step_s;
      SH_RA:   shifted_s = $signed(shift_val_r) >>> step_s;
      default: shifted_s = shift_val_r;
    endcase
    shift_last_s = (remaining_r == step_s);
  end

  // Handshake: DONE can retire and accept on the same edge
  always_comb begin
    case (state_r)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept_s    = in_valid && in_ready;
    shift_now_s = is_shift_s && !illegal_s && (shamt_s != '0);
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx = shift_now_s ? SHIFT : DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (shift_last_s) begin
          state_nx = DONE;
        end else begin
          state_nx = SHIFT;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nx = shift_now_s ? SHIFT : DONE;
        end else if (out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge soc_clk or posedge reset_b) begin
    if (reset_b) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Operand capture, shift iteration and result/flag registers
  always_ff @(posedge soc_clk or posedge reset_b) begin
    if (reset_b) begin
      remaining_r <= '0;
      shift_val_r <= '0;
      kind_r      <= SH_LL;
      result_r    <= '0;
      branch_r    <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
      overflow_r  <= 1'b0;
      carry_r     <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (accept_s && shift_now_s) begin
      shift_val_r <= in_dat1;
      remaining_r <= shamt_s;
      kind_r      <= kind_s;
    end else if (accept_s) begin
      result_r    <= res_s;
      branch_r    <= br_s;
      zero_r      <= zero_s;
      negative_r  <= res_s[XLEN-1];
      overflow_r  <= ovf_s;
      carry_r     <= cy_s;
      illegal_r   <= illegal_s;
    end else if (state_r == SHIFT) begin
      shift_val_r <= shifted_s;
      remaining_r <= remaining_r - step_s;
      if (shift_last_s) begin
        result_r   <= shifted_s;
        branch_r   <= 1'b0;
        zero_r     <= (shifted_s == '0);
        negative_r <= shifted_s[XLEN-1];
        overflow_r <= 1'b0;
        carry_r    <= 1'b0;
        illegal_r  <= 1'b0;
      end
    end
  end

  assign out_valid    = (state_r == DONE);
  assign out_result   = result_r;
  assign out_branch   = branch_r;
  assign out_zero     = zero_r;
  assign out_negative = negative_r;
  assign out_overflow = overflow_r;
  assign out_carry    = carry_r;
  assign out_illegal  = illegal_r;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle ALU. It accepts one RV32I-style ALU or branch-compare operation per transaction over a valid/ready interface and returns a registered result with flags. Shifts are executed iteratively, SHIFT_STEP bits per cycle. The block sits between the control unit's operand fetch and writeback/branch resolution, and it never loses an operand while busy.

## Interface
- XLEN, 32: datapath width. Power of 2, at least 8.
- SHIFT_STEP, 8: maximum shift distance per cycle. Power of 2, from 1 to XLEN.
- soc_clk  in  1  clock; all state updates on the rising edge.
- reset_b  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- in_dat1  in  XLEN  operand A (rs1).
- in_dat2  in  XLEN  operand B (rs2 or immediate); shift amount is in_dat2[log2(XLEN)-1:0].
- in_funct3  in  3  instruction [14:12].
- in_diff  in  1  1 selects SUB or SRA/SRAI.
- in_branch  in  1  1 selects a branch compare; 0 selects an I/R operation.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  I/R result; 0 for branch and illegal operations.
- out_branch  out  1  branch condition true.
- out_zero  out  1  I/R: result==0. Branch: A==B.
- out_negative  out  1  out_result[XLEN-1].
- out_overflow  out  1  signed overflow of ADD/SUB; 0 otherwise.
- out_carry  out  1  ADD: carry out. SUB: borrow (A<B unsigned). 0 otherwise.
- out_illegal  out  1  the operation encoding is illegal.

## Operation
- Decode key is {in_branch, in_diff, in_funct3}.
- Branch operations, in_diff=0:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed).
  - 110 BLTU, 111 BGEU (unsigned).
- I/R operations, in_diff=0:
  - 000 ADD, 001 SLL, 010 SLT, 011 SLTU.
  - 100 XOR, 101 SRL, 110 OR, 111 AND.
- I/R operations, in_diff=1: 000 SUB, 101 SRA.
- Illegal encodings are everything else: branch with funct3 010/011, branch with in_diff=1, and in_diff=1 with any funct3 other than 000/101.
  - An illegal operation still completes with latency 1.
  - It returns out_illegal=1; out_result, out_branch, out_overflow and out_carry are all 0.
- ADD/SUB arithmetic:
  - Computed at XLEN+1 bits.
  - out_result is the low XLEN bits (wrap-around).
  - out_overflow = operand signs match (ADD) or differ (SUB), and the result sign differs from A.
- SLT/SLTU produce 1 or 0, zero-extended.
- State machine has three states: IDLE, SHIFT and DONE.
  - IDLE: in_ready=1. On accept of a non-shift op, or a shift with shamt=0, the result is registered and the FSM goes to DONE. On accept of a shift with shamt>0, the operand and remaining=shamt are loaded and the FSM goes to SHIFT.
  - SHIFT: in_ready=0. Each cycle, shift by min(remaining, SHIFT_STEP) and decrement remaining by the same amount. When remaining reaches 0, go to DONE. SRA fills with the original sign bit.
  - DONE: out_valid=1, and the outputs are held stable until out_ready=1.
    - out_ready=1 with no new accept: go to IDLE.
    - in_ready = out_ready while in DONE. Simultaneous out_ready and in_valid retires the current result and accepts the new op at the same edge, with no bubble.
- Operands and decode are captured at accept. Later changes to in_* do not affect an in-flight op.

## Timing
- Reset (asynchronous assert) forces:
  - state IDLE, remaining 0.
  - out_valid=0 and every out_* output 0.
  - in_ready=1 once reset is released.
- Reset mid-SHIFT or in DONE abandons the operation, and no result is emitted.
- Accept happens at the edge where in_valid&&in_ready=1.
- Non-shift latency: out_valid rises on the accept edge, i.e. a result is visible one cycle after the op is offered.
- Shift latency: out_valid rises ceil(shamt/SHIFT_STEP) edges after the accept edge.
- Throughput:
  - 1 op/cycle for non-shift ops with out_ready held high.
  - Shifts block acceptance for ceil(shamt/SHIFT_STEP) cycles.
- out_valid never drops without out_ready=1, or reset.
- in_ready is combinational from state and out_ready only, never from in_valid.

## Test plan
- Reset mid-shift: accept SRL with shamt=31, assert reset_b after 2 cycles, release -> out_valid=0, in_ready=1, and the next ADD 1+1 returns 2.
- Back-to-back ALU ops with out_ready=1: ADD 0x7FFFFFFF+1, then SUB 0-1, then XOR 0xFF^0x0F -> three consecutive out_valid cycles:
  - 0x80000000 with overflow=1, negative=1.
  - 0xFFFFFFFF with carry=1.
  - 0xF0.
- SRA 0x80000000 by 31 with SHIFT_STEP=8 -> out_valid 4 edges after accept with 0xFFFFFFFF. SLL by 0 -> latency 1 with the operand unchanged.
- Backpressure: out_ready=0 for 5 cycles after an AND result -> out_result held and in_ready=0. Then out_ready=1 with in_valid=1 -> the new op is accepted on the same edge.
- Branches: BLT -1,1 -> branch=1. BLTU 0xFFFFFFFF,1 -> branch=0. BEQ 5,5 -> branch=1, zero=1, out_result=0.
- Illegal encodings {in_branch=1, in_funct3=010} and {in_diff=1, in_funct3=100} -> out_illegal=1, out_result=0, latency 1.
